// File: rtl/uart_irq_ctrl.sv
// uart_irq_ctrl
//   UART interrupt controller. The status vector is registered every cycle.
//   Error-type bits become sticky write-1-to-clear pending flags. Condition
//   bits follow the live status. Pending flags are gated by an enable
//   register, and the result drives one registered irq plus the index of the
//   highest-priority source (bit 0 is highest). After software clears a
//   pending flag, irq is held low for HOLDOFF cycles.
//
// Ports
//   clk        system clock; all state updates on posedge
//   reset      synchronous, active-high reset
//   status     raw status: 0 fe, 1 crce, 2 ore, 3 nf, 4 txi, 5 tbnf, 6 dr, 7 spare
//   ien_we     write strobe for the enable register
//   ien_wdata  new enable mask
//   clr_we     write strobe for the W1C clear
//   clr_wdata  1 = clear that pending bit (edge-mode bits only)
//   status_q   registered status
//   pending    pending flags
//   ien        enable register
//   irq        registered interrupt request
//   irq_id     index of the lowest-numbered enabled pending bit (0 if none)
//
// Handshake: this block has no valid/ready handshakes. Each write strobe is
// a single-cycle command, and it is accepted on the posedge where it is high.
module uart_irq_ctrl #(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] LEVEL_MASK = 8'b0111_0000,
  parameter int               HOLDOFF    = 4,
  parameter int               IDW        = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] status,
  input  logic             ien_we,
  input  logic [WIDTH-1:0] ien_wdata,
  input  logic             clr_we,
  input  logic [WIDTH-1:0] clr_wdata,
  output logic [WIDTH-1:0] status_q,
  output logic [WIDTH-1:0] pending,
  output logic [WIDTH-1:0] ien,
  output logic             irq,
  output logic [IDW-1:0]   irq_id
);

  // Wide enough to hold HOLDOFF. When HOLDOFF is 0, one bit that stays 0.
  localparam int HW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

  logic [WIDTH-1:0] status_prev;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] clr_mask;
  logic [WIDTH-1:0] pending_nxt;
  logic [WIDTH-1:0] active;
  logic             eff_clr;
  logic [IDW-1:0]   id_nxt;
  logic [HW-1:0]    hcnt;
  logic [HW-1:0]    hcnt_nxt;

  always_comb begin
    rise     = status_q & ~status_prev;
    clr_mask = clr_we ? clr_wdata : '0;
    // A clear only counts when it actually drops an edge-mode flag that is
    // set. Clears aimed at level bits or at idle bits start no holdoff.
    eff_clr  = |(clr_mask & pending & ~LEVEL_MASK);
    // Edge bits: a rise wins over a clear in the same cycle, otherwise hold.
    pending_nxt = (LEVEL_MASK & status_q)
                | (~LEVEL_MASK & (rise | (pending & ~clr_mask)));
    active   = pending & ien;

    // Scan from the top down, so the lowest set bit is the one that is kept.
    id_nxt = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (active[i]) id_nxt = IDW'(i);
    end

    hcnt_nxt = hcnt;
    if (eff_clr)           hcnt_nxt = HW'(HOLDOFF);
    else if (hcnt != '0)   hcnt_nxt = hcnt - HW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      status_q    <= '0;
      status_prev <= '0;
      pending     <= '0;
      ien         <= '0;
      irq         <= 1'b0;
      irq_id      <= '0;
      hcnt        <= '0;
    end else begin
      status_q    <= status;
      status_prev <= status_q;
      pending     <= pending_nxt;
      if (ien_we) ien <= ien_wdata;
      // Uses the counter value from before this edge. The same-cycle clear
      // term keeps irq low on the edge where the clear lands.
      irq         <= (|active) && (hcnt == '0) && !eff_clr;
      irq_id      <= id_nxt;
      hcnt        <= hcnt_nxt;
    end
  end

endmodule

// File: tb/tb_uart_irq_ctrl.sv
module tb_uart_irq_ctrl;

  localparam int         W  = 8;
  localparam logic [7:0] LM = 8'b0111_0000;
  localparam int         HO = 4;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] status, ien_wdata, clr_wdata;
  logic       ien_we, clr_we;
  logic [7:0] status_q, pending, ien;
  logic       irq;
  logic [2:0] irq_id;

  always #5 clk = ~clk;

  uart_irq_ctrl #(.WIDTH(W), .LEVEL_MASK(LM), .HOLDOFF(HO), .IDW(3)) dut (
    .clk(clk), .reset(reset), .status(status),
    .ien_we(ien_we), .ien_wdata(ien_wdata),
    .clr_we(clr_we), .clr_wdata(clr_wdata),
    .status_q(status_q), .pending(pending), .ien(ien),
    .irq(irq), .irq_id(irq_id)
  );

  // ---------------- reference model ----------------
  bit m_sq[8], m_sprev[8], m_pend[8], m_ien[8];
  bit m_irq;
  int m_id, m_hcnt;

  int n_checks = 0;
  int n_fails  = 0;

  function automatic logic [7:0] pack(input bit a[8]);
    logic [7:0] v;
    for (int i = 0; i < 8; i++) v[i] = a[i];
    return v;
  endfunction

  // Applies the behavioural rules for one clock edge, using the inputs
  // presented at that edge.
  task automatic model_edge();
    bit n_pend[8];
    bit effective;
    int lowest;
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        m_sq[i] = 0; m_sprev[i] = 0; m_pend[i] = 0; m_ien[i] = 0;
      end
      m_irq = 0; m_id = 0; m_hcnt = 0;
      return;
    end
    effective = 0;
    lowest    = -1;
    for (int i = 0; i < 8; i++) begin
      if (LM[i]) begin
        n_pend[i] = m_sq[i];
      end else begin
        if (clr_we && clr_wdata[i] && m_pend[i]) effective = 1;
        if (m_sq[i] && !m_sprev[i])              n_pend[i] = 1;
        else if (clr_we && clr_wdata[i])         n_pend[i] = 0;
        else                                     n_pend[i] = m_pend[i];
      end
      if (lowest < 0 && m_pend[i] && m_ien[i]) lowest = i;
    end
    m_irq = (lowest >= 0) && (m_hcnt == 0) && !effective;
    m_id  = (lowest >= 0) ? lowest : 0;
    if (effective)       m_hcnt = HO;
    else if (m_hcnt > 0) m_hcnt = m_hcnt - 1;
    for (int i = 0; i < 8; i++) begin
      m_pend[i]  = n_pend[i];
      m_sprev[i] = m_sq[i];
      m_sq[i]    = status[i];
      if (ien_we) m_ien[i] = ien_wdata[i];
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, "/status_q"}, 32'(status_q), 32'(pack(m_sq)));
    check({tag, "/pending"},  32'(pending),  32'(pack(m_pend)));
    check({tag, "/ien"},      32'(ien),      32'(pack(m_ien)));
    check({tag, "/irq"},      32'(irq),      32'(m_irq));
    check({tag, "/irq_id"},   32'(irq_id),   32'(m_id));
    check({tag, "/hcnt"},     32'(dut.hcnt), 32'(m_hcnt));
  endtask

  // ---------------- driver ----------------
  task automatic step(input string tag, input logic [7:0] st,
                      input logic iw = 0, input logic [7:0] id = 8'h00,
                      input logic cw = 0, input logic [7:0] cd = 8'h00,
                      input logic rst = 0);
    status = st; ien_we = iw; ien_wdata = id;
    clr_we = cw; clr_wdata = cd; reset = rst;
    @(posedge clk);
    model_edge();
    #1;
    check_model(tag);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    status = 0; ien_we = 0; ien_wdata = 0; clr_we = 0; clr_wdata = 0; reset = 1;

    // Reset state.
    step("reset", 8'h00, 0, 8'h00, 0, 8'h00, 1);
    check("reset_all", {8'(pending), 8'(ien), 8'(status_q), 5'(irq), irq_id}, 32'h0);

    // Single ore pulse travels through to irq.
    step("ien_ff", 8'h00, 1, 8'hFF);
    step("ore_hi", 8'h04);
    step("ore_lo1", 8'h00);
    check("ore_pending", 32'(pending), 32'h04);
    step("ore_lo2", 8'h00);
    check("ore_irq", {31'd0, irq}, 32'd1);
    check("ore_id", 32'(irq_id), 32'd2);
    step("ore_hold", 8'h00);
    check("ore_sticky", 32'(pending), 32'h04);

    // Add fe, so bit 0 takes priority. Clearing it starts the holdoff.
    step("fe_hi", 8'h01);
    step("fe_lo1", 8'h00);
    check("pend_05", 32'(pending), 32'h05);
    step("fe_lo2", 8'h00);
    check("id_0", 32'(irq_id), 32'd0);
    step("clr_fe", 8'h00, 0, 8'h00, 1, 8'h01);
    check("after_clr_pend", 32'(pending), 32'h04);
    check("after_clr_irq", {31'd0, irq}, 32'd0);
    for (int k = 0; k < HO; k++) begin
      step("holdoff", 8'h00);
      check("holdoff_irq", {31'd0, irq}, 32'd0);
    end
    step("holdoff_end", 8'h00);
    check("resume_irq", {31'd0, irq}, 32'd1);
    check("resume_id", 32'(irq_id), 32'd2);
    step("clr_ore", 8'h00, 0, 8'h00, 1, 8'h04);
    for (int k = 0; k < HO + 1; k++) step("drain", 8'h00);

    // dr is level mode: pending follows it, and clears are ignored.
    step("dr1", 8'h40);
    step("dr2", 8'h40);
    step("dr3_clr", 8'h40, 0, 8'h00, 1, 8'h40);
    check("dr_pend", 32'(pending), 32'h40);
    check("dr_no_holdoff", 32'(dut.hcnt), 32'd0);
    check("dr_irq", {31'd0, irq}, 32'd1);
    check("dr_id", 32'(irq_id), 32'd6);
    step("dr_lo1", 8'h00);
    step("dr_lo2", 8'h00);
    check("dr_pend_gone", 32'(pending), 32'h00);
    step("dr_lo3", 8'h00);
    check("dr_irq_gone", {31'd0, irq}, 32'd0);

    // A rise and a clear on bit 0 in the same cycle: the set wins.
    step("fe_rise", 8'h01);
    step("fe_set_clr", 8'h01, 0, 8'h00, 1, 8'h01);
    check("set_wins", 32'(pending[0]), 32'd1);
    step("fe_clr", 8'h00, 0, 8'h00, 1, 8'h01);
    for (int k = 0; k < HO + 1; k++) step("drain2", 8'h00);

    // crce held high and cleared mid-way does not re-set until it toggles.
    for (int k = 0; k < 10; k++) begin
      if (k == 4) step("crce_clr", 8'h02, 0, 8'h00, 1, 8'h02);
      else        step("crce_hold", 8'h02);
    end
    check("crce_once", 32'(pending[1]), 32'd0);
    step("crce_lo1", 8'h00);
    step("crce_lo2", 8'h00);
    step("crce_hi1", 8'h02);
    step("crce_hi2", 8'h02);
    check("crce_reset", 32'(pending[1]), 32'd1);

    // Everything disabled while four errors are pending, then reset mid-holdoff.
    step("clr_all", 8'h00, 1, 8'h00, 1, 8'hFF);
    for (int k = 0; k < HO + 1; k++) step("drain3", 8'h00);
    step("err4", 8'h0F);
    step("err4_lo1", 8'h00);
    step("err4_lo2", 8'h00);
    check("masked_pend", 32'(pending), 32'h0F);
    check("masked_irq", {31'd0, irq}, 32'd0);
    check("masked_id", 32'(irq_id), 32'd0);
    step("clr_mid", 8'h08, 0, 8'h00, 1, 8'h01);
    check("mid_hcnt", 32'(dut.hcnt), 32'(HO));
    step("rst_mid", 8'h08, 0, 8'h00, 0, 8'h00, 1);
    check("rst_outputs", {8'(pending), 8'(ien), 8'(status_q), 5'(irq), irq_id}, 32'h0);
    check("rst_hcnt", 32'(dut.hcnt), 32'd0);
    step("post_rst1", 8'h08);
    step("post_rst2", 8'h08);
    check("post_rst_rise", 32'(pending), 32'h08);

    // Randomised traffic against the model.
    for (int k = 0; k < 400; k++) begin
      step("rand", 8'($urandom),
           $urandom_range(0, 7) == 0, 8'($urandom),
           $urandom_range(0, 3) == 0, 8'($urandom),
           $urandom_range(0, 63) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
